// File: rtl/pfb_pkg.sv
// pfb_pkg: shared polyphase-filter constants and the output round/saturate helper.
package pfb_pkg;
  localparam int P_W             = 48;
  localparam int DSP_A_W         = 25;
  localparam int DSP_B_W         = 16;
  localparam int PFB_MAC_LATENCY = 4;

  typedef struct packed {
    logic             sat;
    logic [P_W-1:0]   val;
  } rs_t;

  // Round half up at bit shift, then clamp to a signed out_w range; one guard bit keeps the add exact.
  function automatic rs_t round_sat(input logic [P_W-1:0] p, input int shift, input int out_w);
    logic signed [P_W:0] one, r, t, mx, mn;
    rs_t o;
    one   = 1;
    r     = $signed({p[P_W-1], p}) + (one <<< (shift - 1));
    t     = r >>> shift;
    mx    = (one <<< (out_w - 1)) - one;
    mn    = -mx - one;
    o.sat = (t > mx) || (t < mn);
    o.val = (t > mx) ? mx[P_W-1:0] : (t < mn) ? mn[P_W-1:0] : t[P_W-1:0];
    return o;
  endfunction
endpackage

// File: rtl/pfb_mac_out_stage_if.sv
// pfb_mac_out_stage_if: AXI-Stream sample bus with channel index and frame end.
interface pfb_mac_out_stage_if #(
  parameter int OUT_W   = 16,
  parameter int TUSER_W = 8
);
  logic [OUT_W-1:0]   tdata;
  logic               tvalid;
  logic               tready;
  logic [TUSER_W-1:0] tuser;
  logic               tlast;
  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/pfb_skid_fifo2.sv
// pfb_skid_fifo2: two-entry FIFO whose head register drives the outputs directly.
module pfb_skid_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [1:0]    count
);
  logic [DW-1:0] s1;
  logic          pop;
  logic [1:0]    lvl;
  assign valid = count != 2'd0;
  assign pop   = valid & ready;
  // lvl is the occupancy left after this edge's pop, i.e. the slot a push lands in
  assign lvl   = count - {1'b0, pop};
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      dout  <= '0;
      s1    <= '0;
    end else begin
      count <= lvl + {1'b0, push};
      dout  <= (push && lvl == 2'd0) ? din : pop ? s1 : dout;
      s1    <= (push && lvl == 2'd1) ? din : s1;
    end
  end
endmodule

// File: rtl/pfb_mac_out_stage.sv
// pfb_mac_out_stage: tail of the PFB MAC cascade; tracks sideband through the DSP latency and
// emits rounded, saturated samples on AXI-Stream, turning backpressure into the cascade ce.
module pfb_mac_out_stage
  import pfb_pkg::*;
#(
  parameter int LATENCY = PFB_MAC_LATENCY,
  parameter int SHIFT   = 24,
  parameter int OUT_W   = 16,
  parameter int TUSER_W = 8
) (
  input  logic               clk,
  input  logic               sync_reset,
  input  logic               in_valid,
  input  logic [TUSER_W-1:0] in_tuser,
  input  logic               in_tlast,
  output logic               ce_out,
  input  logic [P_W-1:0]     p_in,
  pfb_mac_out_stage_if.master m_axis,
  output logic               sat_flag
);
  localparam int DW = TUSER_W + 1 + OUT_W;

  logic [LATENCY-1:0] pv, pl;
  logic [TUSER_W-1:0] pu [LATENCY];
  logic [OUT_W:0]     rs;
  logic               push;
  logic [DW-1:0]      head;
  logic [1:0]         count;

  function automatic logic [OUT_W:0] rnd(input logic [P_W-1:0] p);
    rs_t r;
    r = round_sat(p, SHIFT, OUT_W);
    return {r.sat, r.val[OUT_W-1:0]};
  endfunction

  // Sideband moves only with ce so it stays aligned with the DSP register stages
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pv <= '0;
      pl <= '0;
      for (int i = 0; i < LATENCY; i++) pu[i] <= '0;
    end else if (ce_out) begin
      pv    <= {pv[LATENCY-2:0], in_valid};
      pl    <= {pl[LATENCY-2:0], in_tlast};
      pu[0] <= in_tuser;
      for (int i = 1; i < LATENCY; i++) pu[i] <= pu[i-1];
    end
  end

  assign rs     = rnd(p_in);
  assign push   = ce_out & pv[LATENCY-1];
  assign ce_out = count != 2'd2;

  always_ff @(posedge clk) begin
    if (sync_reset) sat_flag <= 1'b0;
    else if (push && rs[OUT_W]) sat_flag <= 1'b1;
  end

  pfb_skid_fifo2 #(.DW(DW)) u_fifo (
    .clk   (clk),
    .rst   (sync_reset),
    .push  (push),
    .din   ({pu[LATENCY-1], pl[LATENCY-1], rs[OUT_W-1:0]}),
    .ready (m_axis.tready),
    .dout  (head),
    .valid (m_axis.tvalid),
    .count (count)
  );

  assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = head;
endmodule

// File: tb/tb_pfb_mac_out_stage.sv
// tb_pfb_mac_out_stage: randomized and directed bench against a queue-based behavioural model.
module tb_pfb_mac_out_stage;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        sync_reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_tuser = '0;
  logic        in_tlast = 1'b0;
  logic [47:0] p_in = '0;
  logic        ce_out, sat_flag;

  pfb_mac_out_stage_if #(.OUT_W(16), .TUSER_W(8)) axis ();

  pfb_mac_out_stage dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .in_valid   (in_valid),
    .in_tuser   (in_tuser),
    .in_tlast   (in_tlast),
    .ce_out     (ce_out),
    .p_in       (p_in),
    .m_axis     (axis),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; logic [7:0] u; logic l; } smp_t;
  typedef struct { logic [7:0] u; logic l; int rem; } pend_t;

  smp_t       q[$];
  pend_t      pend[$];
  logic [7:0] log_u[$];
  logic       m_sat = 1'b0;
  int         n_edges = 0;
  int         n_chk = 0, n_fail = 0;
  int         tu = 0;

  function automatic logic [16:0] ref_rs(input logic [47:0] p);
    longint t;
    t = (longint'($signed(p)) + 64'sd8388608) >>> 24;
    if (t > 32767) return {1'b1, 16'h7fff};
    if (t < -32768) return {1'b1, 16'h8000};
    return {1'b0, t[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a sample accepted on a ce edge is captured on the L-th ce edge after it
  always @(posedge clk) begin : model
    bit ce;
    logic [16:0] r;
    n_edges++;
    if (axis.tvalid === 1'b1 && axis.tready) log_u.push_back(axis.tuser);
    if (sync_reset) begin
      q.delete();
      pend.delete();
      m_sat = 1'b0;
    end else begin
      ce = q.size() != 2;
      if (q.size() != 0 && axis.tready) void'(q.pop_front());
      if (ce) begin
        if (pend.size() != 0 && pend[0].rem == 1) begin
          r = ref_rs(p_in);
          q.push_back('{r[15:0], pend[0].u, pend[0].l});
          m_sat = m_sat | r[16];
          void'(pend.pop_front());
        end
        foreach (pend[i]) pend[i].rem--;
        if (in_valid) pend.push_back('{in_tuser, in_tlast, L});
      end
    end
  end

  always @(negedge clk) begin
    if (n_edges > 0) begin
      chk("tvalid", axis.tvalid, q.size() != 0);
      chk("ce_out", ce_out, q.size() != 2);
      chk("sat_flag", sat_flag, m_sat);
      if (q.size() != 0) begin
        chk("tdata", axis.tdata, q[0].d);
        chk("tuser", axis.tuser, q[0].u);
        chk("tlast", axis.tlast, q[0].l);
      end
    end
  end

  task automatic rnd_one(input logic [47:0] p, input logic [15:0] e, input logic es);
    int k;
    @(negedge clk);
    p_in = p; in_valid = 1'b1; in_tuser = 8'h11; in_tlast = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!axis.tvalid && k < 10) begin @(negedge clk); k++; end
    chk("rnd_seen", k < 10, 1);
    chk("rnd_tdata", axis.tdata, e);
    chk("rnd_sat", sat_flag, es);
    @(negedge clk);
  endtask

  // Source that holds its sample while ce_out=0 but shows a poison tuser then
  task automatic stream(input int n, input bit toggle);
    bit acc, pv, pr;
    logic [15:0] pd;
    logic [7:0]  pu;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_tuser = ce_out ? 8'(tu) : 8'hEE;
      in_tlast = (tu % 7) == 6;
      p_in     = {8'h00, 16'(tu * 97), 24'h800000};
      acc      = ce_out;
      if (toggle) axis.tready = ~axis.tready;
      pv = axis.tvalid; pd = axis.tdata; pu = axis.tuser; pr = axis.tready;
      @(negedge clk);
      if (acc) tu++;
      if (pv && !pr) begin
        chk("stall_tdata", axis.tdata, pd);
        chk("stall_tuser", axis.tuser, pu);
      end
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    axis.tready = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic order_chk(input string nm);
    chk({nm, "_cnt"}, log_u.size(), tu);
    foreach (log_u[i]) chk(nm, log_u[i], 8'(i));
  endtask

  initial begin
    int first, hi, frz;
    logic [63:0] w;
    axis.tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tdata", axis.tdata, 0);
    chk("rst_tuser", axis.tuser, 0);
    chk("rst_tlast", axis.tlast, 0);
    chk("rst_ce", ce_out, 1);
    chk("rst_sat", sat_flag, 0);
    sync_reset = 1'b0;

    rnd_one(48'h000000_800000, 16'h0001, 1'b0);
    rnd_one(48'h000000_7FFFFF, 16'h0000, 1'b0);
    rnd_one(48'hFFFFFF_800000, 16'h0000, 1'b0);
    rnd_one(48'hFFFFFF_7FFFFF, 16'hFFFF, 1'b0);
    rnd_one(48'h000080_000000, 16'h0080, 1'b0);
    rnd_one(48'hFFFF00_000000, 16'hFF00, 1'b0);
    rnd_one(48'h007FFF_7FFFFF, 16'h7FFF, 1'b0);
    rnd_one(48'hFF8000_000000, 16'h8000, 1'b0);
    rnd_one(48'h007FFF_800000, 16'h7FFF, 1'b1);
    rnd_one(48'hFF7FFF_000000, 16'h8000, 1'b1);

    @(negedge clk);
    in_valid = 1'b1; in_tuser = 8'd5; in_tlast = 1'b1;
    first = -1; hi = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (axis.tvalid) begin
        hi++;
        if (first < 0) begin
          first = k;
          chk("lat_tuser", axis.tuser, 5);
          chk("lat_tlast", axis.tlast, 1);
        end
      end
    end
    chk("lat_cycles", first, 5);
    chk("lat_width", hi, 1);

    log_u.delete(); tu = 0;
    axis.tready = 1'b0;
    stream(10, 1'b0);
    chk("bp_ce_low", ce_out, 0);
    frz = tu;
    stream(3, 1'b0);
    chk("bp_frozen", tu, frz);
    axis.tready = 1'b1;
    stream(20, 1'b0);
    drain();
    order_chk("bp_order");

    log_u.delete(); tu = 0;
    stream(40, 1'b1);
    drain();
    order_chk("tog_order");

    axis.tready = 1'b0;
    stream(10, 1'b0);
    chk("pre_rst_ce", ce_out, 0);
    sync_reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    sync_reset = 1'b0;
    chk("mid_rst_tvalid", axis.tvalid, 0);
    chk("mid_rst_ce", ce_out, 1);
    chk("mid_rst_sat", sat_flag, 0);
    axis.tready = 1'b1;
    hi = 0;
    repeat (12) begin @(negedge clk); if (axis.tvalid) hi++; end
    chk("mid_rst_stale", hi, 0);

    for (int i = 0; i < 3000; i++) begin
      w = {$urandom, $urandom};
      in_valid    = ($urandom % 4) != 0;
      in_tuser    = 8'($urandom);
      in_tlast    = 1'($urandom);
      axis.tready = ($urandom % 4) != 0;
      sync_reset  = ($urandom % 600) == 0;
      case ($urandom % 3)
        0: p_in = w[47:0];
        1: p_in = {{8{w[39]}}, w[39:0]};
        default: p_in = {{24{w[23]}}, w[23:0]};
      endcase
      @(negedge clk);
    end
    sync_reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
